// File: rtl/counter_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_checker: reference model and scoreboard for up/down counter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module counter_checker #(
  parameter int         WIDTH   = 4,
  parameter logic [7:0] MAX_ERR = 8'd255
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             rco,
  output logic             synced,
  output logic             mismatch,
  output logic             fail,
  output logic [7:0]       err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got
);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_CHECK  = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_all_ones = '1;
  localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_three    = WIDTH'(3);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] exp_val_q, exp_val_d;
  logic             exp_rco_q, exp_rco_d;
  logic             synced_q, synced_d;
  logic             mismatch_q, mismatch_d;
  logic             fail_q, fail_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [15:0]      chk_cnt_q, chk_cnt_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  logic [WIDTH-1:0] nxt_exp;
  logic             nxt_rco;
  logic             cmp_fail;

  // Counter model, driven from the actual sampled Q so one fault never cascades.
  always_comb begin
    nxt_exp = Q;
    nxt_rco = 1'b0;
    if (enb) begin
      case (modo)
        2'b00: begin
          nxt_exp = Q + c_one;
          nxt_rco = (Q == c_all_ones);
        end
        2'b01: begin
          nxt_exp = Q - c_one;
          nxt_rco = (Q == '0);
        end
        2'b10: begin
          nxt_exp = Q - c_three;
          nxt_rco = (Q < c_three);
        end
        default: begin
          nxt_exp = D;
          nxt_rco = 1'b0;
        end
      endcase
    end
  end

  assign cmp_fail = (Q != exp_val_q) || (rco != exp_rco_q);

  always_comb begin
    state_d     = state_q;
    exp_val_d   = exp_val_q;
    exp_rco_d   = exp_rco_q;
    synced_d    = synced_q;
    mismatch_d  = 1'b0;
    fail_d      = fail_q;
    err_cnt_d   = err_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;

    case (state_q)
      ST_UNSYNC: begin
        if (enb && (modo == 2'b11)) begin
          state_d   = ST_CHECK;
          exp_val_d = D;
          exp_rco_d = 1'b0;
          synced_d  = 1'b1;
        end
      end
      ST_CHECK: begin
        if (chk_cnt_q != 16'hFFFF) chk_cnt_d = chk_cnt_q + 16'd1;
        exp_val_d = nxt_exp;
        exp_rco_d = nxt_rco;
        if (cmp_fail) begin
          mismatch_d = 1'b1;
          fail_d     = 1'b1;
          if (err_cnt_q == 8'd0) begin
            first_exp_d = exp_val_q;
            first_got_d = Q;
          end
          if (err_cnt_q < MAX_ERR) err_cnt_d = err_cnt_q + 8'd1;
          if (err_cnt_d == MAX_ERR) begin
            state_d  = ST_HALT;
            synced_d = 1'b0;
          end
        end
      end
      ST_HALT: begin
        fail_d   = 1'b1;
        synced_d = 1'b0;
      end
      default: state_d = ST_UNSYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_UNSYNC;
      exp_val_q   <= '0;
      exp_rco_q   <= 1'b0;
      synced_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= 8'd0;
      chk_cnt_q   <= 16'd0;
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_val_q   <= exp_val_d;
      exp_rco_q   <= exp_rco_d;
      synced_q    <= synced_d;
      mismatch_q  <= mismatch_d;
      fail_q      <= fail_d;
      err_cnt_q   <= err_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  assign synced    = synced_q;
  assign mismatch  = mismatch_q;
  assign fail      = fail_q;
  assign err_cnt   = err_cnt_q;
  assign chk_cnt   = chk_cnt_q;
  assign first_exp = first_exp_q;
  assign first_got = first_got_q;

endmodule
`default_nettype wire

// File: doc/counter_checker.md
# counter_checker

Synchronous reference model and scoreboard that sits directly downstream of the loadable up/down counter. It samples the same `enb`/`modo`/`D` stimulus the counter receives, along with the counter's `Q`/`rco` outputs. It predicts the next `Q`/`rco` every clock, compares prediction against the counter, and reports mismatches, a sticky failure flag and first-failure capture. One instance checks either the 4-bit counter or the cascaded 16-bit counter (with `WIDTH=16`, `rco` tied to `rco1`).

## Interface
- `WIDTH`, 4, data width of `D`/`Q`/expected value.
- `MAX_ERR`, 8'd255, error count at which checking stops (HALT).
- `clk  in  1`  single clock; all sampling on rising edge.
- `reset_L  in  1`  asynchronous, active-low reset.
- `enb  in  1`  counter enable, as driven to the counter.
- `modo  in  2`  counter mode, as driven to the counter.
- `D  in  WIDTH`  load value, as driven to the counter.
- `Q  in  WIDTH`  counter output under check.
- `rco  in  1`  counter ripple-carry output under check.
- `synced  out  1`  expected model valid; comparisons active.
- `mismatch  out  1`  one-cycle pulse; last comparison failed.
- `fail  out  1`  sticky; at least one mismatch since reset.
- `err_cnt  out  8`  mismatch count, saturating at `MAX_ERR`.
- `chk_cnt  out  16`  comparisons performed, saturating at 16'hFFFF.
- `first_exp  out  WIDTH`  expected `Q` at first mismatch.
- `first_got  out  WIDTH`  actual `Q` at first mismatch.

## Operation
- Counter model, applied to the sampled inputs and sampled `Q`, gives `exp_q`/`exp_rco` for the next edge:
  - `enb=0`: `exp_q=Q`, `exp_rco=0`.
  - `modo=00`: `exp_q=Q+1`; `exp_rco=1` iff `Q==2^WIDTH-1`.
  - `modo=01`: `exp_q=Q-1`; `exp_rco=1` iff `Q==0`.
  - `modo=10`: `exp_q=Q-3`; `exp_rco=1` iff `Q<3`.
  - `modo=11`: `exp_q=D`, `exp_rco=0`.
  - All arithmetic is modulo 2^WIDTH; no saturation.
- FSM states:
  - UNSYNC (reset): no comparisons. On an edge sampling `enb=1 && modo=11`, load `exp_q=D`, `exp_rco=0`, go to CHECK.
  - CHECK: each edge compares `{Q,rco}` with `{exp_q,exp_rco}` and then recomputes the expectation from the actual sampled `Q` (resync; a single fault does not cascade). Go to HALT when `err_cnt` reaches `MAX_ERR`.
  - HALT: no compares; `chk_cnt`/`err_cnt` frozen; `fail=1`; `synced=0`. Exits only by reset.
- On mismatch:
  - `err_cnt` increments (saturating).
  - `fail` sets.
  - If `err_cnt` was 0, `first_exp`/`first_got` capture `exp_q`/`Q`; otherwise they are never overwritten.
- A load sampled in CHECK is a normal model step; it does not restart sync.

## Timing
- All outputs are registered. After `reset_L` falls, immediately: state=UNSYNC, all outputs 0, `exp_q=0`, `exp_rco=0`.
- Reset is asserted asynchronously and released synchronously to `clk` by the bench. Reset mid-run discards all history.
- Edge k samples `Q`, which the counter produced at edge k-1. The expectation built at edge k-1 is compared at edge k.
- `mismatch` and the `err_cnt`/`chk_cnt` updates become visible after edge k and persist one cycle. `mismatch` deasserts at edge k+1 unless that compare also fails.
- `synced` rises after the sync edge. The first comparison happens at the following edge.
- In HALT, `mismatch=0`.
- Wrap cases: up from all-ones, down from 0, and down-by-3 from 0/1/2 all expect `rco=1` for exactly one cycle.

## Test plan
- Reset, then 5 edges of `enb=1`, `modo=00` with no load → `synced=0`, `chk_cnt=0`, all outputs 0.
- Load `D=4'hD` (`modo=11`), then 4 edges of `modo=00` on a correct counter → `Q` goes D,E,F,0; `rco=1` only with `Q=0`; `chk_cnt=4`; `fail=0`.
- Load 4'h2, then `modo=10` for 2 edges → `Q` goes 2→F (`rco=1`) →C (`rco=0`); no mismatch.
- Load 4'h5, `modo=01`, with the bench forcing `Q=4'h6` on the next edge → `mismatch` pulse for 1 cycle; `err_cnt=1`; `first_exp=4'h4`; `first_got=4'h6`; following correct cycles give no mismatch.
- `MAX_ERR=3` with `Q` forced wrong on every compare → `err_cnt` stops at 3; state HALT; `synced=0`; `chk_cnt` frozen at 3.
- Assert `reset_L=0` mid-CHECK between edges → all outputs read 0 immediately, without waiting for a clock edge; after release, UNSYNC until the next load.
